// File: rtl/rt_block_reader_if.sv
`default_nettype none
// ==========================================================================
// rt_block_reader_if - control, register read bus and output stream of
// rt_block_reader. Rev 1.0
// ==========================================================================
interface rt_block_reader_if;
   logic        start;
   logic        abort;
   logic [15:0] base_addr;
   logic [7:0]  count;
   logic [31:0] timestamp;
   logic [15:0] reg_raddr;
   logic [31:0] reg_rdata;
   logic        reg_rwait;
   logic        blk_rt_rd;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output start, abort, base_addr, count, timestamp, reg_rdata, reg_rwait, out_ready,
      input  reg_raddr, blk_rt_rd, out_data, out_valid, busy, done, err
   );

   modport slave (
      input  start, abort, base_addr, count, timestamp, reg_rdata, reg_rwait, out_ready,
      output reg_raddr, blk_rt_rd, out_data, out_valid, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/rt_block_reader.sv
`default_nettype none
// ==========================================================================
// rt_block_reader - reads a block of registers and streams them out.
// Define RT_TIMESTAMP_EN to emit a captured timestamp word first. Rev 1.0
// ==========================================================================
module rt_block_reader #(
   parameter int RWAIT_MAX = 15
) (
   input wire               sysclk,
   input wire               reset,
   rt_block_reader_if.slave bus
);
   localparam logic [7:0] WAIT_LAST = 8'(RWAIT_MAX - 1);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      WAIT = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [15:0] base_q, raddr_q;
   logic [7:0]  count_q, index_q, wcnt_q;
   logic [7:0]  index_inc;
   logic [31:0] data_q;
   logic        err_q;
   logic        start_acc, accept, timeout, more;
   logic        valid_o, busy_o, done_o;
`ifdef RT_TIMESTAMP_EN
   logic        ts_pending;
`endif

   assign index_inc = index_q + 8'd1;

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      start_acc = 1'b0;
      accept    = 1'b0;
      timeout   = 1'b0;
      more      = 1'b0;
      valid_o   = 1'b0;
      busy_o    = 1'b0;
      done_o    = 1'b0;
      if (state == WAIT)
         timeout = bus.reg_rwait && (wcnt_q == WAIT_LAST);
`ifdef RT_TIMESTAMP_EN
      if (state == OUT)
         more = ts_pending ? (count_q != 8'd0) : (index_inc < count_q);
`else
      if (state == OUT)
         more = index_inc < count_q;
`endif
      // abort outranks everything, including the handshake of the current cycle
      if (state != IDLE && bus.abort) begin
         state_nxt = IDLE;
      end else begin
         busy_o  = (state != IDLE);
         done_o  = (state == DONE);
         valid_o = (state == OUT);
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  start_acc = 1'b1;
`ifdef RT_TIMESTAMP_EN
                  state_nxt = OUT;
`else
                  state_nxt = (bus.count == 8'd0) ? DONE : ADDR;
`endif
               end
            end
            ADDR: state_nxt = WAIT;
            WAIT: if (!bus.reg_rwait || timeout) state_nxt = OUT;
            OUT: begin
               if (bus.out_ready) begin
                  accept    = 1'b1;
                  state_nxt = more ? ADDR : DONE;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         base_q  <= '0;
         raddr_q <= '0;
         count_q <= '0;
         index_q <= '0;
         wcnt_q  <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef RT_TIMESTAMP_EN
         ts_pending <= 1'b0;
`endif
      end else begin
         if (start_acc) begin
            base_q  <= bus.base_addr;
            raddr_q <= bus.base_addr;
            count_q <= bus.count;
            index_q <= '0;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
`ifdef RT_TIMESTAMP_EN
            data_q     <= bus.timestamp;
            ts_pending <= 1'b1;
`endif
         end
         if (state == WAIT && !bus.abort) begin
            if (!bus.reg_rwait) begin
               data_q <= bus.reg_rdata;
            end else if (timeout) begin
               data_q <= '1;
               err_q  <= 1'b1;
            end else begin
               wcnt_q <= wcnt_q + 8'd1;
            end
         end
         if (accept) begin
            wcnt_q <= '0;
`ifdef RT_TIMESTAMP_EN
            // the timestamp word consumes no bus cycle, so the address stays at base
            if (ts_pending) begin
               ts_pending <= 1'b0;
            end else begin
               index_q <= index_inc;
               raddr_q <= base_q + {8'd0, index_inc};
            end
`else
            index_q <= index_inc;
            raddr_q <= base_q + {8'd0, index_inc};
`endif
         end
      end
   end

   assign bus.reg_raddr = raddr_q;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_o;
   assign bus.busy      = busy_o;
   assign bus.blk_rt_rd = busy_o;
   assign bus.done      = done_o;
   assign bus.err       = err_q;
endmodule
`default_nettype wire

// File: tb/tb_rt_block_reader.sv
`default_nettype none
// tb_rt_block_reader - directed scoreboard bench for rt_block_reader.
module tb_rt_block_reader;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

`ifdef RT_TIMESTAMP_EN
   localparam bit TS_MODE = 1'b1;
`else
   localparam bit TS_MODE = 1'b0;
`endif

   rt_block_reader_if bus ();

   rt_block_reader #(.RWAIT_MAX(15)) dut (
      .sysclk (clk),
      .reset  (rst),
      .bus    (bus.slave)
   );

   typedef struct {
      bit          is_done;
      bit          chk_lat;
      logic [31:0] data;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] pend[$];
   int          n_checks = 0;
   int          n_fail   = 0;

   logic [31:0] ts_ctr = 32'h1000_0000;
   always @(posedge clk) ts_ctr <= ts_ctr + 32'd1;
   assign bus.timestamp = ts_ctr;

   // responder: holds rwait for stall_len cycles while stall_addr is on the bus
   logic [15:0] stall_addr = 16'hDEAD;
   int          stall_len  = 0;
   int          used       = 0;
   assign bus.reg_rwait = (bus.reg_raddr == stall_addr) && (used < stall_len);
   assign bus.reg_rdata = bus.reg_rwait ? 32'hDEADBEEF : {16'hC0DE, bus.reg_raddr};
   always @(posedge clk)
      used <= (bus.reg_raddr == stall_addr) ? used + (bus.reg_rwait ? 1 : 0) : 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic fail(input string name, input logic [31:0] act);
      n_checks++;
      n_fail++;
      $display("FAIL %s: got %h, expected nothing", name, act);
   endtask

   // monitor
   longint      cyc = 0;
   longint      last_acc = -10;
   bit          held = 1'b0;
   logic [31:0] held_data = '0;
   exp_t        mon_e;
   always @(negedge clk) begin
      cyc++;
      chk("blk_rt_rd_eq_busy", {31'd0, bus.blk_rt_rd}, {31'd0, bus.busy});
      if (bus.out_valid && held)
         chk("stall_hold", bus.out_data, held_data);
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            fail("unexpected_word", bus.out_data);
         end else begin
            mon_e = sb.pop_front();
            if (mon_e.is_done) fail("word_before_done", bus.out_data);
            else               chk("word", bus.out_data, mon_e.data);
         end
         last_acc = cyc;
      end
      held      = bus.out_valid && !bus.out_ready;
      held_data = bus.out_data;
      if (bus.done) begin
         if (sb.size() == 0) begin
            fail("unexpected_done", 32'd1);
         end else begin
            mon_e = sb.pop_front();
            if (!mon_e.is_done)    fail("done_before_word", mon_e.data);
            else if (mon_e.chk_lat) chk("done_latency", 32'(cyc), 32'(last_acc + 1));
         end
      end
   end

   task automatic issue(input logic [15:0] b, input logic [7:0] c, input bit want_done,
                        input bit lat);
      exp_t e;
      @(posedge clk); #1;
      bus.base_addr = b;
      bus.count     = c;
      bus.start     = 1'b1;
      e.is_done = 1'b0;
      e.chk_lat = 1'b0;
`ifdef RT_TIMESTAMP_EN
      e.data = ts_ctr;
      sb.push_back(e);
`endif
      while (pend.size() > 0) begin
         e.data = pend.pop_front();
         sb.push_back(e);
      end
      if (want_done) begin
         e.is_done = 1'b1;
         e.chk_lat = lat;
         e.data    = '0;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 100);
      if (!bus.out_valid) fail("wait_valid_timeout", 32'(n));
   endtask

   task automatic wait_done();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.done && n < 200);
      if (!bus.done) fail("wait_done_timeout", 32'(n));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.base_addr = '0;
      bus.count     = '0;
      bus.out_ready = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_raddr", {16'd0, bus.reg_raddr}, 32'd0);
      chk("rst_out_data", bus.out_data, 32'd0);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // plain three-word read, then a start during the DONE cycle
      pend = {32'hC0DE0010, 32'hC0DE0011, 32'hC0DE0012};
      issue(16'h0010, 8'd3, 1'b1, 1'b1);
      wait_valid(n);
`ifndef RT_TIMESTAMP_EN
      chk("read_latency", 32'(n), 32'd3);
`endif
      chk("busy_mid_read", {31'd0, bus.busy}, 32'd1);
      wait_done();
      bus.start     = 1'b1;
      bus.base_addr = 16'h0099;
      bus.count     = 8'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("start_in_done_ignored", {31'd0, bus.busy}, 32'd0);

      // wait states on the second read, plus a start while busy
      stall_addr = 16'h0021;
      stall_len  = 5;
      pend = {32'hC0DE0020, 32'hC0DE0021, 32'hC0DE0022};
      issue(16'h0020, 8'd3, 1'b1, 1'b1);
      bus.start     = 1'b1;
      bus.base_addr = 16'h0077;
      bus.count     = 8'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done();
      chk("err_after_short_wait", {31'd0, bus.err}, 32'd0);
      stall_addr = 16'hDEAD;

      // stuck rwait on the first read; sequence continues
      stall_addr = 16'h0040;
      stall_len  = 1000;
      pend = {32'hFFFFFFFF, 32'hC0DE0041};
      issue(16'h0040, 8'd2, 1'b1, 1'b1);
      wait_valid(n);
`ifndef RT_TIMESTAMP_EN
      chk("timeout_latency", 32'(n), 32'd17);
      chk("err_on_timeout", {31'd0, bus.err}, 32'd1);
`endif
      wait_done();
      chk("err_sticky", {31'd0, bus.err}, 32'd1);
      stall_addr = 16'hDEAD;

      // address wrap with a stalled consumer; start clears err
      bus.out_ready = 1'b0;
      pend = {32'hC0DEFFFF, 32'hC0DE0000};
      issue(16'hFFFF, 8'd2, 1'b1, 1'b1);
      @(negedge clk);
      chk("err_cleared_by_start", {31'd0, bus.err}, 32'd0);
      wait_valid(n);
      repeat (5) begin
         @(negedge clk);
         chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
      end
`ifndef RT_TIMESTAMP_EN
      chk("stall_data", bus.out_data, 32'hC0DEFFFF);
`endif
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      wait_done();

      // abort during the second OUT word
      bus.out_ready = 1'b0;
`ifndef RT_TIMESTAMP_EN
      pend = {32'hC0DE0030};
`endif
      issue(16'h0030, 8'd3, 1'b0, 1'b0);
      wait_valid(n);
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b0;
      wait_valid(n);
      @(posedge clk); #1;
      bus.abort = 1'b1;
      @(negedge clk);
      chk("abort_valid_low", {31'd0, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      bus.abort     = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, bus.busy}, 32'd0);
      chk("abort_err_kept", {31'd0, bus.err}, 32'd0);

      // start together with abort in IDLE
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.abort     = 1'b1;
      bus.base_addr = 16'h0033;
      bus.count     = 8'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      @(negedge clk);
      chk("start_abort_ignored", {31'd0, bus.busy}, 32'd0);

      // asynchronous reset in the middle of WAIT
      stall_addr = 16'h0050;
      stall_len  = 1000;
      issue(16'h0050, 8'd1, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
      chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("midrst_raddr", {16'd0, bus.reg_raddr}, 32'd0);
      chk("midrst_data", bus.out_data, 32'd0);
      @(posedge clk); #1;
      rst        = 1'b0;
      stall_addr = 16'hDEAD;

      // zero-length block
      issue(16'h0060, 8'd0, 1'b1, TS_MODE);
      wait_done();
      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/rt_block_reader.md
RT_BLOCK_READER -- requirements
Module: rt_block_reader

Interface
REQ-001 Parameter: RWAIT_MAX, 15, maximum consecutive reg_rwait cycles tolerated per read (1..255).
REQ-002 Port: sysclk  input  1  system clock, 49.152 MHz; all logic on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  single-cycle request to begin a block read; ignored while busy=1.
REQ-005 Port: abort  input  1  terminates any sequence in progress.
REQ-006 Port: base_addr  input  16  first register address; sampled on accepted start.
REQ-007 Port: count  input  8  number of register words to read; sampled on accepted start.
REQ-008 Port: timestamp  input  32  free-running timestamp.
REQ-009 Port: reg_raddr  output  16  register read address driven onto the read bus.
REQ-010 Port: reg_rdata  input  32  register read data from the responder.
REQ-011 Port: reg_rwait  input  1  responder wait state; read data not valid while high.
REQ-012 Port: blk_rt_rd  output  1  high for the entire duration of a real-time block read.
REQ-013 Port: out_data  output  32  streamed word.
REQ-014 Port: out_valid  output  1  out_data valid.
REQ-015 Port: out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-016 Port: busy  output  1  sequence in progress.
REQ-017 Port: done  output  1  one-cycle pulse after the last word is accepted.
REQ-018 Port: err  output  1  sticky; set on any rwait timeout, cleared on the next accepted start.

Function
REQ-019 States SHALL be IDLE, ADDR, WAIT, OUT, DONE.
REQ-020 IDLE: when start=1, latch base_addr and count, clear err, and set busy; go to ADDR, or to DONE when count=0 (no bus cycle, no word).
REQ-021 ADDR: drive reg_raddr = base_addr + index, where index runs 0..count-1 and the 16-bit add wraps modulo 2^16; go to WAIT on the next cycle.
REQ-022 WAIT: if reg_rwait=0, capture reg_rdata into out_data and go to OUT; read latency is therefore 2 cycles minimum from entering ADDR.
REQ-023 WAIT: count consecutive rwait=1 cycles; on reaching RWAIT_MAX, load out_data=32'hFFFFFFFF, set err, and go to OUT.
REQ-024 OUT: hold out_valid=1 and out_data stable until out_ready=1; on acceptance, increment index, then go to ADDR if index<count, else go to DONE.
REQ-025 reg_raddr SHALL remain stable from ADDR through the capture cycle.
REQ-026 DONE: pulse done for one cycle, clear busy, and return to IDLE.
REQ-027 blk_rt_rd SHALL equal busy.
REQ-028 abort=1 in any state other than IDLE: next state IDLE, out_valid=0, busy=0, no done pulse, err unchanged; abort has priority over every other transition.
REQ-029 start=1 together with abort=1 in IDLE: abort wins and start is ignored.
REQ-030 start=1 in the DONE cycle SHALL be ignored.

Reset
REQ-031 While reset=1: state=IDLE; reg_raddr=0; out_data=0; out_valid=0; busy=0; blk_rt_rd=0; done=0; err=0; index and wait counter=0.
REQ-032 Reset asserted mid-sequence SHALL abandon the sequence immediately, with no done pulse.

Configuration
REQ-033 Macro RT_TIMESTAMP_EN defined: on an accepted start, timestamp is captured and emitted as the first OUT word, before any bus read and without a bus cycle.
REQ-034 With RT_TIMESTAMP_EN defined, count=0 still emits the timestamp word and then goes to DONE.
REQ-035 RT_TIMESTAMP_EN undefined: no timestamp word is emitted; the timestamp input is unused.

Verification
REQ-036 start, base_addr=16'h0010, count=3, rwait=0, out_ready=1 -> addresses 0x0010/0x0011/0x0012 driven; 3 words out; done 1 cycle after last accept; blk_rt_rd high throughout.
REQ-037 rwait held high 4 cycles on the second read -> out_data equals reg_rdata sampled in the first rwait=0 cycle; err=0.
REQ-038 rwait stuck high -> after 15 cycles out_data=32'hFFFFFFFF, err=1, and the sequence continues; err clears on the next start.
REQ-039 base_addr=16'hFFFF, count=2, with out_ready low for 5 cycles -> reg_raddr is 0xFFFF then 0x0000; out_data is held stable while stalled.
REQ-040 abort during the second OUT, and reset asserted mid-WAIT -> IDLE, busy=0, no done; a subsequent start with count=0 gives a done pulse and zero words (one timestamp word with RT_TIMESTAMP_EN).
